// File: rtl/issue_split.sv
// Dual-issue bundle splitter; RAW-dependent bundles are serialised through pipe1 (ISSUE_SPLIT_STATS_EN adds a split counter).
// Latency: 1 cycle from accept to registered outputs; a split bundle takes 2 issue slots.
// Backpressure: ready drops on downstream stall, while holding slot 2, and during flush.
module issue_split #(
    parameter int IW = 32
`ifdef ISSUE_SPLIT_STATS_EN
    , parameter int CW = 16
`endif
) (
    input  logic          is_i_clk,
    input  logic          is_i_rst_n,
    input  logic          is_i_flush,
    input  logic          is_i_valid,
    output logic          is_o_ready,
    input  logic [IW-1:0] is_i_instr_1,
    input  logic [IW-1:0] is_i_instr_2,
    input  logic          is_i_valid_2,
    input  logic          is_i_force_pipe1,
    input  logic          is_i_ds_ready,
    output logic          is_o_p1_valid,
    output logic [IW-1:0] is_o_p1_instr,
    output logic          is_o_p1_replay,
    output logic          is_o_p2_valid,
    output logic [IW-1:0] is_o_p2_instr
`ifdef ISSUE_SPLIT_STATS_EN
    , output logic [CW-1:0] is_o_split_cnt
`endif
);

    typedef enum logic {ST_PASS, ST_HOLD} state_t;

    state_t        r_state;
    logic          r_p1_vld;
    logic [IW-1:0] r_p1_instr;
    logic          r_p1_replay;
    logic          r_p2_vld;
    logic [IW-1:0] r_p2_instr;
    logic [IW-1:0] r_hold_instr;

    state_t        w_state_nxt;
    logic          w_p1_vld_nxt;
    logic [IW-1:0] w_p1_instr_nxt;
    logic          w_p1_replay_nxt;
    logic          w_p2_vld_nxt;
    logic [IW-1:0] w_p2_instr_nxt;
    logic [IW-1:0] w_hold_instr_nxt;

    logic          w_adv;
    logic          w_ready;
    logic          w_acc;
    logic          w_split;

    assign w_adv   = !r_p1_vld || is_i_ds_ready;
    // Gated by reset so ready reads 0 while the block is held in reset.
    assign w_ready = is_i_rst_n && (r_state == ST_PASS) && w_adv && !is_i_flush;
    assign w_acc   = is_i_valid && w_ready;
    assign w_split = w_acc && is_i_valid_2 && is_i_force_pipe1;

    always_comb begin
        w_state_nxt      = r_state;
        w_p1_vld_nxt     = r_p1_vld;
        w_p1_instr_nxt   = r_p1_instr;
        w_p1_replay_nxt  = r_p1_replay;
        w_p2_vld_nxt     = r_p2_vld;
        w_p2_instr_nxt   = r_p2_instr;
        w_hold_instr_nxt = r_hold_instr;
        if (is_i_flush) begin
            w_state_nxt     = ST_PASS;
            w_p1_vld_nxt    = 1'b0;
            w_p1_replay_nxt = 1'b0;
            w_p2_vld_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (w_acc) begin
                        w_p1_vld_nxt    = 1'b1;
                        w_p1_instr_nxt  = is_i_instr_1;
                        w_p1_replay_nxt = 1'b0;
                        w_p2_vld_nxt    = 1'b0;
                        if (is_i_valid_2 && !is_i_force_pipe1) begin
                            w_p2_vld_nxt   = 1'b1;
                            w_p2_instr_nxt = is_i_instr_2;
                        end else if (is_i_valid_2) begin
                            w_hold_instr_nxt = is_i_instr_2;
                            w_state_nxt      = ST_HOLD;
                        end
                    end else if (w_adv) begin
                        w_p1_vld_nxt    = 1'b0;
                        w_p1_replay_nxt = 1'b0;
                        w_p2_vld_nxt    = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_adv) begin
                        w_p1_vld_nxt    = 1'b1;
                        w_p1_instr_nxt  = r_hold_instr;
                        w_p1_replay_nxt = 1'b1;
                        w_p2_vld_nxt    = 1'b0;
                        w_state_nxt     = ST_PASS;
                    end
                end
                default: w_state_nxt = ST_PASS;
            endcase
        end
    end

    always_ff @(posedge is_i_clk or negedge is_i_rst_n) begin
        if (!is_i_rst_n) begin
            r_state      <= ST_PASS;
            r_p1_vld     <= 1'b0;
            r_p1_instr   <= '0;
            r_p1_replay  <= 1'b0;
            r_p2_vld     <= 1'b0;
            r_p2_instr   <= '0;
            r_hold_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_p1_vld     <= w_p1_vld_nxt;
            r_p1_instr   <= w_p1_instr_nxt;
            r_p1_replay  <= w_p1_replay_nxt;
            r_p2_vld     <= w_p2_vld_nxt;
            r_p2_instr   <= w_p2_instr_nxt;
            r_hold_instr <= w_hold_instr_nxt;
        end
    end

    assign is_o_ready     = w_ready;
    assign is_o_p1_valid  = r_p1_vld;
    assign is_o_p1_instr  = r_p1_instr;
    assign is_o_p1_replay = r_p1_replay;
    assign is_o_p2_valid  = r_p2_vld;
    assign is_o_p2_instr  = r_p2_instr;

`ifdef ISSUE_SPLIT_STATS_EN
    logic [CW-1:0] r_split_cnt;

    // Saturating; survives flush so the statistic spans redirects.
    always_ff @(posedge is_i_clk or negedge is_i_rst_n) begin
        if (!is_i_rst_n) begin
            r_split_cnt <= '0;
        end else if (w_split && (r_split_cnt != {CW{1'b1}})) begin
            r_split_cnt <= r_split_cnt + CW'(1);
        end
    end

    assign is_o_split_cnt = r_split_cnt;
`else
    logic w_split_unused;
    assign w_split_unused = w_split;
`endif

endmodule

// File: tb/tb_issue_split.sv
// Directed bench for issue_split: pass, split/replay, stalls, flush, async reset, counter saturation.
module tb_issue_split;

    localparam int IW = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          vld;
    logic          rdy;
    logic [IW-1:0] i1;
    logic [IW-1:0] i2;
    logic          v2;
    logic          force1;
    logic          ds_rdy;
    logic          p1_vld;
    logic [IW-1:0] p1_instr;
    logic          p1_replay;
    logic          p2_vld;
    logic [IW-1:0] p2_instr;
`ifdef ISSUE_SPLIT_STATS_EN
    logic [3:0]    cnt;
`endif

    int checks = 0;
    int errors = 0;

    issue_split #(
        .IW(IW)
`ifdef ISSUE_SPLIT_STATS_EN
        , .CW(4)
`endif
    ) dut (
        .is_i_clk        (clk),
        .is_i_rst_n      (rst_n),
        .is_i_flush      (flush),
        .is_i_valid      (vld),
        .is_o_ready      (rdy),
        .is_i_instr_1    (i1),
        .is_i_instr_2    (i2),
        .is_i_valid_2    (v2),
        .is_i_force_pipe1(force1),
        .is_i_ds_ready   (ds_rdy),
        .is_o_p1_valid   (p1_vld),
        .is_o_p1_instr   (p1_instr),
        .is_o_p1_replay  (p1_replay),
        .is_o_p2_valid   (p2_vld),
        .is_o_p2_instr   (p2_instr)
`ifdef ISSUE_SPLIT_STATS_EN
        , .is_o_split_cnt(cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic [IW-1:0] a, input logic [IW-1:0] b,
                          input logic s2, input logic f);
        vld = 1'b1; i1 = a; i2 = b; v2 = s2; force1 = f;
    endtask

    task automatic outs(input string tag, input logic ev1, input logic [IW-1:0] e1,
                        input logic erp, input logic ev2);
        chk({tag, ".p1_vld"}, 64'(p1_vld), 64'(ev1));
        if (ev1) chk({tag, ".p1_instr"}, 64'(p1_instr), 64'(e1));
        chk({tag, ".replay"}, 64'(p1_replay), 64'(erp));
        chk({tag, ".p2_vld"}, 64'(p2_vld), 64'(ev2));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; vld = 1'b0; i1 = '0; i2 = '0;
        v2 = 1'b0; force1 = 1'b0; ds_rdy = 1'b1;
        #3;
        chk("rst.p1_vld", 64'(p1_vld), 64'd0);
        chk("rst.p1_instr", 64'(p1_instr), 64'd0);
        chk("rst.p2_vld", 64'(p2_vld), 64'd0);
        chk("rst.p2_instr", 64'(p2_instr), 64'd0);
        chk("rst.replay", 64'(p1_replay), 64'd0);
        chk("rst.ready", 64'(rdy), 64'd0);
`ifdef ISSUE_SPLIT_STATS_EN
        chk("rst.cnt", 64'(cnt), 64'd0);
`endif
        #9;
        rst_n = 1'b1;
        #1;
        chk("post_rst.ready", 64'(rdy), 64'd1);

        // Independent bundles back to back, then a bubble
        bundle(32'hA000_0001, 32'hB000_0002, 1'b1, 1'b0);
        cyc();
        outs("ind1", 1'b1, 32'hA000_0001, 1'b0, 1'b1);
        chk("ind1.p2_instr", 64'(p2_instr), 64'hB000_0002);
        chk("ind1.ready", 64'(rdy), 64'd1);
        bundle(32'hC000_0003, 32'hD000_0004, 1'b1, 1'b0);
        cyc();
        outs("ind2", 1'b1, 32'hC000_0003, 1'b0, 1'b1);
        chk("ind2.p2_instr", 64'(p2_instr), 64'hD000_0004);
        vld = 1'b0;
        cyc();
        outs("bubble", 1'b0, '0, 1'b0, 1'b0);
        chk("bubble.ready", 64'(rdy), 64'd1);

        // Hazard bundle: split then replay
        bundle(32'hE000_0005, 32'hF000_0006, 1'b1, 1'b1);
        cyc();
        outs("haz1", 1'b1, 32'hE000_0005, 1'b0, 1'b0);
        chk("haz1.ready", 64'(rdy), 64'd0);
        vld = 1'b0;
        cyc();
        outs("haz2", 1'b1, 32'hF000_0006, 1'b1, 1'b0);
        chk("haz2.ready", 64'(rdy), 64'd1);
`ifdef ISSUE_SPLIT_STATS_EN
        chk("haz2.cnt", 64'(cnt), 64'd1);
`endif
        cyc();
        outs("haz3", 1'b0, '0, 1'b0, 1'b0);

        // Downstream stall while holding slot 2
        bundle(32'h1111_0007, 32'h2222_0008, 1'b1, 1'b1);
        cyc();
        vld = 1'b0; ds_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            outs("hstall", 1'b1, 32'h1111_0007, 1'b0, 1'b0);
            chk("hstall.ready", 64'(rdy), 64'd0);
        end
        ds_rdy = 1'b1;
        #1;
        chk("hstall_rel.ready", 64'(rdy), 64'd0);
        cyc();
        outs("hrel", 1'b1, 32'h2222_0008, 1'b1, 1'b0);
        chk("hrel.ready", 64'(rdy), 64'd1);
`ifdef ISSUE_SPLIT_STATS_EN
        chk("hrel.cnt", 64'(cnt), 64'd2);
`endif

        // Single-instruction bundle ignores the force flag
        bundle(32'h3333_0009, 32'h4444_000A, 1'b0, 1'b1);
        cyc();
        outs("single", 1'b1, 32'h3333_0009, 1'b0, 1'b0);
        chk("single.ready", 64'(rdy), 64'd1);
`ifdef ISSUE_SPLIT_STATS_EN
        chk("single.cnt", 64'(cnt), 64'd2);
`endif
        vld = 1'b0;
        cyc();

        // Flush in HOLD with a bundle presented and downstream ready
        bundle(32'h5555_000B, 32'h6666_000C, 1'b1, 1'b1);
        cyc();
        bundle(32'h7777_000D, 32'h8888_000E, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush.ready", 64'(rdy), 64'd0);
        cyc();
        flush = 1'b0; vld = 1'b0;
        outs("flush", 1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("postflush.ready", 64'(rdy), 64'd1);
        cyc();
        outs("postflush", 1'b0, '0, 1'b0, 1'b0);
`ifdef ISSUE_SPLIT_STATS_EN
        chk("flush.cnt", 64'(cnt), 64'd3);
`endif

        // Downstream stall in PASS blocks the next bundle
        bundle(32'h9999_000F, 32'hAAAA_0010, 1'b1, 1'b0);
        cyc();
        bundle(32'hBBBB_0011, 32'hCCCC_0012, 1'b1, 1'b0);
        ds_rdy = 1'b0;
        #1;
        chk("pstall.ready", 64'(rdy), 64'd0);
        cyc();
        outs("pstall", 1'b1, 32'h9999_000F, 1'b0, 1'b1);
        chk("pstall.p2_instr", 64'(p2_instr), 64'hAAAA_0010);
        ds_rdy = 1'b1;
        cyc();
        outs("prel", 1'b1, 32'hBBBB_0011, 1'b0, 1'b1);
        chk("prel.p2_instr", 64'(p2_instr), 64'hCCCC_0012);
        vld = 1'b0;
        cyc();

        // Asynchronous reset in HOLD drops the held instruction
        bundle(32'hDDDD_0013, 32'hEEEE_0014, 1'b1, 1'b1);
        cyc();
        vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        outs("arst", 1'b0, '0, 1'b0, 1'b0);
`ifdef ISSUE_SPLIT_STATS_EN
        chk("arst.cnt", 64'(cnt), 64'd0);
`endif
        #3;
        rst_n = 1'b1;
        cyc();
        outs("arst_rel", 1'b0, '0, 1'b0, 1'b0);
        chk("arst_rel.ready", 64'(rdy), 64'd1);

`ifdef ISSUE_SPLIT_STATS_EN
        // Counter saturation at CW=4
        for (int n = 1; n <= 17; n++) begin
            bundle(32'h0100_0000 + n, 32'h0200_0000 + n, 1'b1, 1'b1);
            cyc();
            vld = 1'b0;
            cyc();
            if (n == 14) chk("sat.cnt14", 64'(cnt), 64'd14);
            if (n == 15) chk("sat.cnt15", 64'(cnt), 64'd15);
        end
        chk("sat.cnt17", 64'(cnt), 64'd15);
        outs("sat.last", 1'b1, 32'h0200_0011, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
